// File: rtl/or4_pkg.sv
// Shared types and constants for the four-input OR gate stimulus generator.
package or4_pkg;

    localparam int PATTERN_W = 4;
    localparam logic [PATTERN_W-1:0] LAST_PATTERN = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/or4_prescaler.sv
// Modulo-STEP_CYCLES counter with enable and synchronous clear.
// The tick output is high on the enabled cycle in which the count wraps.
module or4_prescaler #(
    parameter int STEP_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // With STEP_CYCLES=1 the counter stays at zero and ticks on every enabled edge.
    assign tick = en && !clr && (cnt == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/or4_stimulus_gen.sv
// Binary sweep generator driving the four OR gate inputs through 0..15,
// with a per-pattern strobe and the expected gate output for a checker.
module or4_stimulus_gen
    import or4_pkg::*;
#(
    parameter int STEP_CYCLES = 5,
    parameter int SWEEPS      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 hold,
    output logic                 in_a,
    output logic                 in_b,
    output logic                 in_c,
    output logic                 in_d,
    output logic [PATTERN_W-1:0] pattern,
    output logic                 step,
    output logic                 expected_y,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           sweep_cnt
);

    localparam logic [7:0] LAST_SWEEP = 8'(SWEEPS);

    state_t               state, state_nx;
    logic [PATTERN_W-1:0] pattern_nx;
    logic [7:0]           sweep_nx;
    logic                 step_nx;
    logic                 tick;

    or4_prescaler #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  ((state == RUN) && !hold),
        .clr ((state != RUN) || stop),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pattern   <= '0;
            sweep_cnt <= '0;
            step      <= 1'b0;
        end else begin
            state     <= state_nx;
            pattern   <= pattern_nx;
            sweep_cnt <= sweep_nx;
            step      <= step_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_nx   = state;
        pattern_nx = pattern;
        sweep_nx   = sweep_cnt;
        step_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx   = RUN;
                    pattern_nx = '0;
                    sweep_nx   = '0;
                    step_nx    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx   = IDLE;
                    pattern_nx = '0;
                end else if (tick) begin
                    // tick is already gated by hold, so a held cycle falls through.
                    if (pattern != LAST_PATTERN) begin
                        pattern_nx = pattern + 4'd1;
                        step_nx    = 1'b1;
                    end else begin
                        pattern_nx = '0;
                        sweep_nx   = sweep_cnt + 8'd1;
                        if (sweep_nx == LAST_SWEEP) begin
                            state_nx = DONE;
                        end else begin
                            step_nx = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign {in_d, in_c, in_b, in_a} = pattern;
    assign expected_y = |pattern;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_or4_stimulus_gen.sv
// Self-checking bench for or4_stimulus_gen: three configurations, a per-cycle
// reference model and a scoreboard of the patterns announced by step.
module tb_or4_stimulus_gen;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       step;
        logic [3:0] pattern;
        logic       exp_y;
        logic [3:0] ins;
        logic [7:0] sweep;
    } snap_t;

    typedef struct packed {
        logic [1:0] inst;
        logic [3:0] pat;
        logic       y;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start, stop, hold;
    logic [2:0] in_a, in_b, in_c, in_d, step, expected_y, busy, done;
    logic [3:0] pattern   [3];
    logic [7:0] sweep_cnt [3];

    int  checks = 0;
    int  errors = 0;
    sb_t exp_q[$];

    always #5 clk = ~clk;

    or4_stimulus_gen #(.STEP_CYCLES(5), .SWEEPS(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]), .hold(hold[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_c(in_c[0]), .in_d(in_d[0]),
        .pattern(pattern[0]), .step(step[0]), .expected_y(expected_y[0]),
        .busy(busy[0]), .done(done[0]), .sweep_cnt(sweep_cnt[0])
    );

    or4_stimulus_gen #(.STEP_CYCLES(5), .SWEEPS(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]), .hold(hold[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_c(in_c[1]), .in_d(in_d[1]),
        .pattern(pattern[1]), .step(step[1]), .expected_y(expected_y[1]),
        .busy(busy[1]), .done(done[1]), .sweep_cnt(sweep_cnt[1])
    );

    or4_stimulus_gen #(.STEP_CYCLES(1), .SWEEPS(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .stop(stop[2]), .hold(hold[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_c(in_c[2]), .in_d(in_d[2]),
        .pattern(pattern[2]), .step(step[2]), .expected_y(expected_y[2]),
        .busy(busy[2]), .done(done[2]), .sweep_cnt(sweep_cnt[2])
    );

    function automatic snap_t obs(input int i);
        snap_t s;
        s.busy    = busy[i];
        s.done    = done[i];
        s.step    = step[i];
        s.pattern = pattern[i];
        s.exp_y   = expected_y[i];
        s.ins     = {in_d[i], in_c[i], in_b[i], in_a[i]};
        s.sweep   = sweep_cnt[i];
        return s;
    endfunction

    // Expected outputs e edges after the start edge of an uninterrupted run.
    function automatic snap_t model(input int sc, input int sw, input int e);
        snap_t s;
        int    total;
        total = 16 * sc * sw;
        s = '0;
        if (e < total) begin
            s.busy    = 1'b1;
            s.step    = (e % sc) == 0;
            s.pattern = 4'((e / sc) % 16);
            s.sweep   = 8'(e / (16 * sc));
        end else begin
            s.done  = (e == total);
            s.sweep = 8'(sw);
        end
        s.exp_y = |s.pattern;
        s.ins   = s.pattern;
        return s;
    endfunction

    task automatic push_run(input int inst, input int n);
        sb_t x;
        for (int k = 0; k < n; k++) begin
            x.inst = 2'(inst);
            x.pat  = 4'(k % 16);
            x.y    = (k % 16) != 0;
            exp_q.push_back(x);
        end
    endtask

    // Advance one edge, sample 1 time unit later and retire strobed patterns.
    task automatic clk_edge();
        sb_t x;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (step[i] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow inst %0d got pattern %h required no step", i, pattern[i]);
                end else begin
                    x = exp_q.pop_front();
                    if (x.inst != 2'(i) || pattern[i] !== x.pat || expected_y[i] !== x.y) begin
                        errors++;
                        $display("FAIL sb_pattern inst %0d got %0d/%h/%b required %0d/%h/%b",
                                 i, i, pattern[i], expected_y[i], x.inst, x.pat, x.y);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = '0; stop = '0; hold = '0;
        #2 rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== '0) begin
                errors++;
                $display("FAIL reset_state inst %0d got %h required %h", i, obs(i), snap_t'('0));
            end
        end
        #8 rst = 1'b0;
    endtask

    task automatic test_single_sweep();
        snap_t exp;
        int    n_step;
        n_step = 0;
        push_run(0, 16);
        start[0] = 1'b1;
        for (int e = 0; e <= 81; e++) begin
            clk_edge();
            start[0] = 1'b0;
            exp = model(5, 1, e);
            if (step[0] === 1'b1) n_step++;
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL single_sweep cycle %0d got %h required %h", e, obs(0), exp);
            end
        end
        checks++;
        if (n_step != 16) begin
            errors++;
            $display("FAIL single_sweep_steps got %0d required 16", n_step);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_sweep_leftover got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_hold();
        snap_t exp;
        int    t, n3;
        n3 = 0;
        push_run(0, 16);
        start[0] = 1'b1;
        for (int e = 0; e <= 88; e++) begin
            clk_edge();
            start[0] = 1'b0;
            // Edges 18..24 are held while pattern 3 sits at prescaler 2.
            t = (e < 18) ? e : ((e <= 24) ? 17 : e - 7);
            exp = model(5, 1, t);
            if (pattern[0] === 4'd3) n3++;
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL hold cycle %0d got %h required %h", e, obs(0), exp);
            end
            hold[0] = (e + 1 >= 18) && (e + 1 <= 24);
        end
        checks++;
        if (n3 != 12) begin
            errors++;
            $display("FAIL hold_pattern3_len got %0d required 12", n3);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_leftover got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_stop_and_ignored_start();
        snap_t exp;
        push_run(0, 10);
        start[0] = 1'b1;
        for (int e = 0; e <= 50; e++) begin
            clk_edge();
            start[0] = 1'b0;
            exp = (e < 47) ? model(5, 1, e) : snap_t'('0);
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL stop cycle %0d got %h required %h", e, obs(0), exp);
            end
            stop[0] = (e + 1 == 47);
        end
        push_run(0, 16);
        start[0] = 1'b1;
        for (int e = 0; e <= 82; e++) begin
            clk_edge();
            exp = model(5, 1, e);
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL ignored_start cycle %0d got %h required %h", e, obs(0), exp);
            end
            start[0] = (e + 1 == 20) || (e + 1 == 60) || (e + 1 == 81);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stop_leftover got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        snap_t exp;
        push_run(1, 23);
        start[1] = 1'b1;
        for (int e = 0; e <= 112; e++) begin
            clk_edge();
            start[1] = 1'b0;
            exp = model(5, 2, e);
            checks++;
            if (obs(1) !== exp) begin
                errors++;
                $display("FAIL mid_run cycle %0d got %h required %h", e, obs(1), exp);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs(1) !== '0) begin
            errors++;
            $display("FAIL mid_run_reset got %h required %h", obs(1), snap_t'('0));
        end
        #1 rst = 1'b0;
        push_run(1, 32);
        start[1] = 1'b1;
        for (int e = 0; e <= 161; e++) begin
            clk_edge();
            start[1] = 1'b0;
            exp = model(5, 2, e);
            checks++;
            if (obs(1) !== exp) begin
                errors++;
                $display("FAIL restart cycle %0d got %h required %h", e, obs(1), exp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_run_leftover got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_boundary();
        snap_t exp;
        push_run(2, 48);
        start[2] = 1'b1;
        for (int e = 0; e <= 49; e++) begin
            clk_edge();
            start[2] = 1'b0;
            exp = model(1, 3, e);
            checks++;
            if (obs(2) !== exp) begin
                errors++;
                $display("FAIL boundary cycle %0d got %h required %h", e, obs(2), exp);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL boundary_leftover got %0d required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_hold();
        test_stop_and_ignored_start();
        test_reset_mid_run();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or4_stimulus_gen.md
Name: or4_stimulus_gen

Overview:
Upstream stimulus stage for the four-input OR gate exercise. It replaces the free-running clk_a..clk_d dividers with a controllable binary sweep generator. On a start request it drives the four gate inputs through all 16 combinations {d,c,b,a} = 0..15, holding each combination for a programmable number of clock cycles, and repeats for a programmable number of sweeps. Alongside the stimulus it presents a strobe and the expected OR result, so a downstream checker can compare them against the gate output y.

Parameters:
STEP_CYCLES, 5, clock cycles each combination is held (>=1); bit a toggles every STEP_CYCLES cycles, b every 2x, c every 4x, d every 8x
SWEEPS, 1, number of full 0..15 sweeps per start (>=1, <=255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a run; sampled only in IDLE
stop  input  1  synchronous abort; returns to IDLE from any state
hold  input  1  freezes prescaler and pattern while high in RUN
in_a  output  1  gate input a (pattern[0])
in_b  output  1  gate input b (pattern[1])
in_c  output  1  gate input c (pattern[2])
in_d  output  1  gate input d (pattern[3])
pattern  output  4  current combination {d,c,b,a}
step  output  1  one-cycle strobe, high in the first cycle a new pattern is presented
expected_y  output  1  |pattern, derived from registered pattern only
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
sweep_cnt  output  8  completed sweeps in the current run

Behaviour:
- Reset (async, rst=1): state=IDLE; pattern=0; prescaler=0; sweep_cnt=0; step=0; busy=0; done=0; in_a..in_d=0; expected_y=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge where start=1 and stop=0. At that edge pattern=0, prescaler=0, sweep_cnt=0, step=1 in the following cycle. start=1 together with stop=1 in IDLE stays in IDLE.
- RUN, per edge, in priority order:
  - stop=1: go to IDLE, clear pattern and prescaler, busy=0, no done pulse.
  - hold=1: all counters unchanged, step=0.
  - prescaler != STEP_CYCLES-1: prescaler+1.
  - Otherwise (advance edge): prescaler=0.
    - pattern<15: pattern+1, step=1 in the next cycle.
    - pattern=15: wrap to 0 and increment sweep_cnt.
    - If the new sweep_cnt = SWEEPS: go to DONE with pattern=0.
    - Otherwise stay in RUN with step=1.
- Hold time: each pattern is presented for exactly STEP_CYCLES cycles when hold=0, so one sweep lasts 16*STEP_CYCLES cycles. STEP_CYCLES=1 advances on every edge.
- DONE: done=1 and busy=0 for one cycle, then IDLE unconditionally. stop has no additional effect. start is ignored.
- start in RUN or DONE is ignored. It is not queued.
- Prescaler width is $clog2(STEP_CYCLES), minimum 1 bit. sweep_cnt saturates by construction because SWEEPS<=255.
- in_a..in_d, pattern and sweep_cnt are register outputs, so the downstream OR gate sees glitch-free inputs. expected_y is a function of the registered pattern.

Decomposition:
- Shared package or4_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - PATTERN_W=4;
  - LAST_PATTERN=4'hF.
- One natural sub-module: or4_prescaler, a modulo-STEP_CYCLES counter with enable (=RUN & !hold) and synchronous clear, outputting a tick on its terminal count. The FSM, pattern and sweep counters stay in or4_stimulus_gen.

Test Plan:
- Reset value check: rst pulsed asynchronously mid-cycle -> all outputs 0 immediately, state IDLE.
- Single sweep (STEP_CYCLES=5, SWEEPS=1): one-cycle start at edge E0 -> pattern=1 at E5 and 15 at E75; DONE with done=1 at E80; IDLE at E81. step pulses 16 times, and expected_y=0 only while pattern=0.
- Hold: hold=1 for 7 cycles while pattern=3 with prescaler=2 -> pattern 3 lasts 12 cycles total and no step during the hold.
- Stop and ignored start: stop at pattern=9 -> IDLE next edge, pattern=0, no done pulse. start pulsed during RUN -> no restart, total run length unchanged.
- Reset mid-run: rst asserted at pattern=6 with SWEEPS=2, sweep_cnt=1 -> immediate clear. A subsequent start begins again from pattern=0, sweep_cnt=0.
- Boundary configuration (STEP_CYCLES=1, SWEEPS=3): pattern advances every edge, sweep_cnt reaches 1, 2, 3. done arrives 48 cycles after entering RUN, with step high continuously until DONE.
